ucode_loader: RTL and testbench

UCODE_LOADER -- requirements
Module: ucode_loader

---
 rtl/ucode_loader_pkg.sv | 15 +
 rtl/ucode_loader_if.sv | 26 ++
 rtl/ucode_chksum.sv | 34 +++
 rtl/ucode_loader.sv | 115 +++++++++++
 tb/tb_ucode_loader.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ucode_loader_pkg.sv
// rtl/ucode_loader_pkg.sv - shared loader states and default control-store geometry
package ucode_loader_pkg;

  localparam int LP_LOG_MEMSIZE = 4;
  localparam int LP_WORD_WIDTH  = 11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } state_e;

endpackage

// File: rtl/ucode_loader_if.sv
// rtl/ucode_loader_if.sv - word stream in and control-store write port out of the loader
interface ucode_loader_if import ucode_loader_pkg::*; #(
  parameter int P_LOG_MEMSIZE = LP_LOG_MEMSIZE,
  parameter int P_WORD_WIDTH  = LP_WORD_WIDTH
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [P_WORD_WIDTH-1:0]  in_data;
  logic                     in_last;
  logic                     mem_we;
  logic [P_LOG_MEMSIZE-1:0] mem_addr;
  logic [P_WORD_WIDTH-1:0]  mem_wdata;

  // master feeds words and observes the store; slave is the loader
  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/ucode_chksum.sv
// rtl/ucode_chksum.sv - XOR accumulator over loaded words with equality compare
module ucode_chksum #(
  parameter int P_WORD_WIDTH = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    acc_en,
  input  logic [P_WORD_WIDTH-1:0] din,
  output logic                    match
);

  logic [P_WORD_WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (acc_en) begin
      acc_d = acc_q ^ din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign match = (acc_q == din);

endmodule

// File: rtl/ucode_loader.sv
// rtl/ucode_loader.sv - streams microcode into the control store, then enables the CPU; UCODE_LOADER_CHKSUM_EN adds a trailing XOR checksum word
module ucode_loader import ucode_loader_pkg::*; #(
  parameter int P_LOG_MEMSIZE = LP_LOG_MEMSIZE,
  parameter int P_WORD_WIDTH  = LP_WORD_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          halt,
  ucode_loader_if.slave bus,
  output logic          cpu_en,
  output logic          busy,
  output logic          err
);

  localparam logic [P_LOG_MEMSIZE-1:0] LP_LAST_ADDR = '1;

  state_e                   state_q, state_d;
  logic [P_LOG_MEMSIZE-1:0] cnt_q, cnt_d;
  logic                     mem_we_q, mem_we_d;
  logic [P_LOG_MEMSIZE-1:0] mem_addr_q, mem_addr_d;
  logic [P_WORD_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic                     cpu_en_q, cpu_en_d;
  logic                     in_ready;
  logic                     accept;

  assign accept = bus.in_valid && in_ready;

`ifdef UCODE_LOADER_CHKSUM_EN
  localparam state_e LP_AFTER_LOAD = ST_CHECK;
  logic chk_ok;

  ucode_chksum #(
    .P_WORD_WIDTH(P_WORD_WIDTH)
  ) u_chksum (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_IDLE && start),
    .acc_en (state_q == ST_LOAD && accept),
    .din    (bus.in_data),
    .match  (chk_ok)
  );
`else
  localparam state_e LP_AFTER_LOAD = ST_RUN;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_en_q    <= cpu_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        // a non-last word at the top address has nowhere to go after it
        if (accept) begin
          if (bus.in_last) begin
            state_d = LP_AFTER_LOAD;
          end else if (cnt_q == LP_LAST_ADDR) begin
            state_d = ST_ERROR;
          end
        end
      end
`ifdef UCODE_LOADER_CHKSUM_EN
      ST_CHECK: if (accept) state_d = chk_ok ? ST_RUN : ST_ERROR;
`endif
      ST_RUN:   if (halt) state_d = ST_IDLE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    busy        = in_ready;
    err         = (state_q == ST_ERROR);
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    // registered one cycle behind RUN so the CPU never steps before the final write lands
    cpu_en_d    = (state_q == ST_RUN) && !halt;
    if (state_q == ST_IDLE && start) begin
      cnt_d = '0;
    end
    if (state_q == ST_LOAD && accept) begin
      mem_we_d    = 1'b1;
      mem_addr_d  = cnt_q;
      mem_wdata_d = bus.in_data;
      cnt_d       = cnt_q + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_en        = cpu_en_q;

endmodule

// File: tb/tb_ucode_loader.sv
// tb/tb_ucode_loader.sv - directed bench for ucode_loader; checksum cases build with UCODE_LOADER_CHKSUM_EN
module tb_ucode_loader;

  logic clk;
  logic rst;
  logic start;
  logic halt;
  logic cpu_en;
  logic busy;
  logic err;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0]  wa[$];
  logic [10:0] wd[$];

  ucode_loader_if bus ();

  ucode_loader dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .halt   (halt),
    .bus    (bus),
    .cpu_en (cpu_en),
    .busy   (busy),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wa.push_back(bus.mem_addr);
      wd.push_back(bus.mem_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic go_idle();
    @(negedge clk) halt = 1'b1;
    @(negedge clk) halt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk) bus.in_valid = 1'b0;
  endtask

  // returns just after the posedge that accepts the word
  task automatic send(input logic [10:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      check_eq("send_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
    end else begin
      @(posedge clk);
    end
  endtask

  // called right after the final program word is accepted
  task automatic run_check(input string tag, input logic [10:0] chk);
`ifdef UCODE_LOADER_CHKSUM_EN
    send(chk, 1'b0);
`endif
    #1 check_eq({tag, "_cpu_en_n1"}, {31'd0, cpu_en}, 32'd0);
    idle();
    @(posedge clk);
    #1 check_eq({tag, "_cpu_en_n2"}, {31'd0, cpu_en}, 32'd1);
    check_eq({tag, "_busy_run"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    check_eq({tag, "_mem_we"}, {31'd0, bus.mem_we}, 32'd0);
    check_eq({tag, "_mem_addr"}, {28'd0, bus.mem_addr}, 32'd0);
    check_eq({tag, "_mem_wdata"}, {21'd0, bus.mem_wdata}, 32'd0);
    check_eq({tag, "_cpu_en"}, {31'd0, cpu_en}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  initial begin
    logic [10:0] t1_d[3];
    logic [10:0] t3_d[4];
    t1_d = '{11'h001, 11'h002, 11'h7FF};
    t3_d = '{11'h0A5, 11'h15A, 11'h3C3, 11'h700};

    rst = 1'b0;
    start = 1'b0;
    halt = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    #1 rst = 1'b1;
    #22 check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // three-word program, last word 0x7FF
    clear_log();
    pulse_start();
    check_eq("t1_busy_load", {31'd0, busy}, 32'd1);
    send(t1_d[0], 1'b0);
    send(t1_d[1], 1'b0);
    send(t1_d[2], 1'b1);
    #1 check_eq("t1_last_we", {31'd0, bus.mem_we}, 32'd1);
    check_eq("t1_last_addr", {28'd0, bus.mem_addr}, 32'd2);
    check_eq("t1_last_data", {21'd0, bus.mem_wdata}, 32'h7FF);
    run_check("t1", 11'h7FC);
    check_eq("t1_nwrites", wa.size(), 32'd3);
    for (int i = 0; i < 3 && i < wa.size(); i++) begin
      check_eq($sformatf("t1_addr%0d", i), {28'd0, wa[i]}, i);
      check_eq($sformatf("t1_data%0d", i), {21'd0, wd[i]}, {21'd0, t1_d[i]});
    end

    // halt and start together in RUN: halt wins
    @(negedge clk);
    halt = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 check_eq("t2_cpu_en_halt", {31'd0, cpu_en}, 32'd0);
    check_eq("t2_busy_halt", {31'd0, busy}, 32'd0);
    check_eq("t2_ready_halt", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    halt = 1'b0;
    start = 1'b0;
    clear_log();
    pulse_start();
    @(negedge clk) halt = 1'b1;
    @(posedge clk);
    #1 check_eq("t2_halt_in_load", {31'd0, busy}, 32'd1);
    @(negedge clk) halt = 1'b0;
    send(11'h123, 1'b1);
    run_check("t2", 11'h123);
    check_eq("t2_nwrites", wa.size(), 32'd1);
    if (wa.size() > 0) begin
      check_eq("t2_addr0", {28'd0, wa[0]}, 32'd0);
      check_eq("t2_data0", {21'd0, wd[0]}, 32'h123);
    end

    // in_valid gaps between every word
    go_idle();
    clear_log();
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send(t3_d[i], i == 3);
      if (i < 3) begin
        idle();
        @(negedge clk);
      end
    end
    run_check("t3", 11'h0A5 ^ 11'h15A ^ 11'h3C3 ^ 11'h700);
    check_eq("t3_nwrites", wa.size(), 32'd4);
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      check_eq($sformatf("t3_addr%0d", i), {28'd0, wa[i]}, i);
      check_eq($sformatf("t3_data%0d", i), {21'd0, wd[i]}, {21'd0, t3_d[i]});
    end

    // asynchronous reset in the middle of a load
    go_idle();
    pulse_start();
    send(11'h011, 1'b0);
    send(11'h022, 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("t4_midload");
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    clear_log();
    pulse_start();
    send(11'h055, 1'b1);
    run_check("t4", 11'h055);
    check_eq("t4_nwrites", wa.size(), 32'd1);
    if (wa.size() > 0) begin
      check_eq("t4_addr0", {28'd0, wa[0]}, 32'd0);
    end

    // overflow: 16 words and none marked last
    go_idle();
    clear_log();
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      send(11'h100 + 11'(i), 1'b0);
    end
    #1 check_eq("t5_top_we", {31'd0, bus.mem_we}, 32'd1);
    check_eq("t5_top_addr", {28'd0, bus.mem_addr}, 32'd15);
    check_eq("t5_err", {31'd0, err}, 32'd1);
    check_eq("t5_ready", {31'd0, bus.in_ready}, 32'd0);
    idle();
    pulse_start();
    go_idle();
    repeat (3) @(negedge clk);
    check_eq("t5_err_sticky", {31'd0, err}, 32'd1);
    check_eq("t5_cpu_en", {31'd0, cpu_en}, 32'd0);
    check_eq("t5_busy", {31'd0, busy}, 32'd0);
    check_eq("t5_nwrites", wa.size(), 32'd16);
    for (int i = 0; i < 16 && i < wa.size(); i++) begin
      check_eq($sformatf("t5_addr%0d", i), {28'd0, wa[i]}, i);
      check_eq($sformatf("t5_data%0d", i), {21'd0, wd[i]}, 32'h100 + i);
    end
    do_reset();
    check_eq("t5_err_cleared", {31'd0, err}, 32'd0);

`ifdef UCODE_LOADER_CHKSUM_EN
    // matching and mismatching checksum
    clear_log();
    pulse_start();
    send(11'h00F, 1'b0);
    send(11'h0F0, 1'b1);
    run_check("t6", 11'h0FF);
    check_eq("t6_err", {31'd0, err}, 32'd0);
    do_reset();
    clear_log();
    pulse_start();
    send(11'h00F, 1'b0);
    send(11'h0F0, 1'b1);
    send(11'h0FE, 1'b0);
    #1 check_eq("t6_bad_err", {31'd0, err}, 32'd1);
    check_eq("t6_bad_cpu_en", {31'd0, cpu_en}, 32'd0);
    idle();
    repeat (3) @(negedge clk);
    check_eq("t6_bad_cpu_en_later", {31'd0, cpu_en}, 32'd0);
    check_eq("t6_bad_nwrites", wa.size(), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
